// File: rtl/nbank_buf_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nbank_buf_ctrl_pkg : shared state encodings and bank-count legality check  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package nbank_buf_ctrl_pkg;

   // Encodings are shared with the weight-buffer controller; keep values fixed.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int MIN_BANKS = 2;
   localparam int MAX_BANKS = 8;

   function automatic bit num_banks_legal(input int n);
      return (n >= MIN_BANKS) && (n <= MAX_BANKS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/nbank_buf_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nbank_buf_ctrl_if : writer/reader handshake and status bundle              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface nbank_buf_ctrl_if #(
   parameter int NUM_BANKS  = 2,
   parameter int TILE_CNT_W = 16
);
   localparam int BANK_W = $clog2(NUM_BANKS);

   logic                  Ctrl_start;
   logic                  write_finish;
   logic                  last_tile;
   logic                  done_tile;
   logic [BANK_W-1:0]     wr_bank;
   logic [BANK_W-1:0]     rd_bank;
   logic                  wr_ready;
   logic                  rd_valid;
   logic [NUM_BANKS-1:0]  bank_full;
   logic [TILE_CNT_W-1:0] tile_cnt;
   logic                  busy;
   logic                  all_done;
   logic                  err;

   modport master (
      output Ctrl_start, write_finish, last_tile, done_tile,
      input  wr_bank, rd_bank, wr_ready, rd_valid, bank_full, tile_cnt, busy, all_done, err
   );

   modport slave (
      input  Ctrl_start, write_finish, last_tile, done_tile,
      output wr_bank, rd_bank, wr_ready, rd_valid, bank_full, tile_cnt, busy, all_done, err
   );

endinterface
`default_nettype wire

// File: rtl/nbank_buf_ctrl_bank_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nbank_buf_ctrl_bank_ptr : modulo-NUM_BANKS wrap counter, inc + sync clear  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module nbank_buf_ctrl_bank_ptr #(
   parameter int NUM_BANKS = 2,
   parameter int BANK_W    = $clog2(NUM_BANKS)
) (
   input  logic              clki,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   output logic [BANK_W-1:0] ptr
);
   localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

   logic [BANK_W-1:0] ptr_q;
   logic [BANK_W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (inc) begin
         ptr_d = (ptr_q == LAST_BANK) ? '0 : ptr_q + BANK_W'(1);
      end
   end

   always_ff @(posedge clki) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/nbank_buf_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nbank_buf_ctrl : N-bank tile buffer controller (writer/reader rotation)    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module nbank_buf_ctrl
   import nbank_buf_ctrl_pkg::*;
#(
   parameter int NUM_BANKS  = 2,
   parameter int TILE_CNT_W = 16
) (
   input  logic             clki,
   input  logic             rst,
   nbank_buf_ctrl_if.slave  bus
);
   localparam int BANK_W = $clog2(NUM_BANKS);

   if (!num_banks_legal(NUM_BANKS)) begin : g_bad_num_banks
      $error("nbank_buf_ctrl: NUM_BANKS must be in 2..8");
   end

   state_e                state_q, state_d;
   logic [NUM_BANKS-1:0]  full_q, full_d;
   logic [TILE_CNT_W-1:0] cnt_q, cnt_d;
   logic                  err_q, err_d;

   logic [BANK_W-1:0]     wr_ptr;
   logic [BANK_W-1:0]     rd_ptr;
   logic                  start_ok;
   logic                  wr_ready;
   logic                  rd_valid;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  reject;

   assign start_ok = (state_q == ST_IDLE) & bus.Ctrl_start;
   assign wr_ready = (state_q == ST_RUN) & ~full_q[wr_ptr];
   assign rd_valid = (state_q != ST_IDLE) & full_q[rd_ptr];
   assign wr_acc   = bus.write_finish & wr_ready;
   assign rd_acc   = bus.done_tile & rd_valid;
   assign reject   = (bus.write_finish & ~wr_ready) | (bus.done_tile & ~rd_valid);

   nbank_buf_ctrl_bank_ptr #(
      .NUM_BANKS (NUM_BANKS),
      .BANK_W    (BANK_W)
   ) u_wr_ptr (
      .clki (clki),
      .rst  (rst),
      .clr  (start_ok),
      .inc  (wr_acc),
      .ptr  (wr_ptr)
   );

   nbank_buf_ctrl_bank_ptr #(
      .NUM_BANKS (NUM_BANKS),
      .BANK_W    (BANK_W)
   ) u_rd_ptr (
      .clki (clki),
      .rst  (rst),
      .clr  (start_ok),
      .inc  (rd_acc),
      .ptr  (rd_ptr)
   );

   // A start in IDLE wins over any stray pulse in the same cycle, so err starts clean.
   always_comb begin
      state_d = state_q;
      full_d  = full_q;
      cnt_d   = cnt_q;
      err_d   = err_q | reject;
      if (start_ok) begin
         state_d = ST_RUN;
         full_d  = '0;
         cnt_d   = '0;
         err_d   = 1'b0;
      end else begin
         if (wr_acc) begin
            full_d[wr_ptr] = 1'b1;
         end
         if (rd_acc) begin
            full_d[rd_ptr] = 1'b0;
            cnt_d          = cnt_q + TILE_CNT_W'(1);
         end
         case (state_q)
            ST_RUN:   if (wr_acc && bus.last_tile) state_d = ST_DRAIN;
            ST_DRAIN: if (full_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clki) begin
      if (rst) begin
         state_q <= ST_IDLE;
         full_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         full_q  <= full_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign bus.wr_bank   = wr_ptr;
   assign bus.rd_bank   = rd_ptr;
   assign bus.wr_ready  = wr_ready;
   assign bus.rd_valid  = rd_valid;
   assign bus.bank_full = full_q;
   assign bus.tile_cnt  = cnt_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.all_done  = (state_q == ST_DONE);
   assign bus.err       = err_q;

endmodule
`default_nettype wire
